// File: rtl/frequency_analyzer_if.sv
// Bus bundle for the frequency analyzer: window controls, the measured
// signal, and the published measurement result.
interface frequency_analyzer_if #(
  parameter int COUNTER_WIDTH = 32
);

  logic                     enable;
  logic                     start_analyzer;
  logic                     stop_analyzer;
  logic                     sample_in;
  logic [COUNTER_WIDTH-1:0] frequency;
  logic                     frequency_valid;
  logic                     overflow;
  logic                     busy;

  // The controller side drives the window and the signal under test.
  modport master (
    output enable,
    output start_analyzer,
    output stop_analyzer,
    output sample_in,
    input  frequency,
    input  frequency_valid,
    input  overflow,
    input  busy
  );

  // The analyzer side consumes the controls and publishes the result.
  modport slave (
    input  enable,
    input  start_analyzer,
    input  stop_analyzer,
    input  sample_in,
    output frequency,
    output frequency_valid,
    output overflow,
    output busy
  );

endinterface

// File: rtl/frequency_analyzer.sv
// Frequency analyzer: counts rising edges of an asynchronous input between
// a window-open and a window-close level, and publishes the saturating
// count with a one-cycle valid pulse and an overflow flag.
module frequency_analyzer #(
  parameter int COUNTER_WIDTH = 32,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  frequency_analyzer_if.slave   bus
);

  typedef enum logic {
    IDLE,
    COUNT
  } state_t;

  localparam logic [COUNTER_WIDTH-1:0] CountMax   = '1;
  localparam logic [COUNTER_WIDTH-1:0] CountMaxM1 = {{(COUNTER_WIDTH-1){1'b1}}, 1'b0};

  logic [SYNC_STAGES-1:0]   r_sync;
  logic                     r_samplePrev;
  logic                     r_sampleEdge;
  logic                     r_startPrev;
  logic                     r_stopPrev;
  logic                     r_armed;

  state_t                   r_state;
  logic [COUNTER_WIDTH-1:0] r_counter;
  logic                     r_sat;
  logic [COUNTER_WIDTH-1:0] r_frequency;
  logic                     r_overflow;
  logic                     r_valid;
  logic                     r_busy;

  logic                     w_startRise;
  logic                     w_stopRise;
  logic [COUNTER_WIDTH-1:0] w_incCounter;
  logic                     w_incSat;
  state_t                   w_nextState;
  logic [COUNTER_WIDTH-1:0] w_nextCounter;
  logic                     w_nextSat;
  logic [COUNTER_WIDTH-1:0] w_nextFrequency;
  logic                     w_nextOverflow;
  logic                     w_nextValid;

  // Input conditioning runs regardless of enable; r_armed masks the first
  // cycle after reset so levels held across reset release are not seen as rises.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync       <= '0;
      r_samplePrev <= 1'b0;
      r_sampleEdge <= 1'b0;
      r_startPrev  <= 1'b0;
      r_stopPrev   <= 1'b0;
      r_armed      <= 1'b0;
    end else begin
      r_sync       <= {r_sync[SYNC_STAGES-2:0], bus.sample_in};
      r_samplePrev <= r_sync[SYNC_STAGES-1];
      r_sampleEdge <= r_sync[SYNC_STAGES-1] & ~r_samplePrev;
      r_startPrev  <= bus.start_analyzer;
      r_stopPrev   <= bus.stop_analyzer;
      r_armed      <= 1'b1;
    end
  end

  assign w_startRise = r_armed & bus.start_analyzer & ~r_startPrev;
  assign w_stopRise  = r_armed & bus.stop_analyzer  & ~r_stopPrev;

  // Window control and saturating edge count; everything holds while disabled.
  always_comb begin
    w_nextState     = r_state;
    w_nextCounter   = r_counter;
    w_nextSat       = r_sat;
    w_nextFrequency = r_frequency;
    w_nextOverflow  = r_overflow;
    w_nextValid     = 1'b0;
    w_incCounter    = r_counter;
    w_incSat        = r_sat;

    if (r_sampleEdge) begin
      if (r_counter == CountMax) begin
        w_incCounter = CountMax;
        w_incSat     = 1'b1;
      end else begin
        w_incCounter = r_counter + 1'b1;
        w_incSat     = r_sat | (r_counter == CountMaxM1);
      end
    end

    if (bus.enable) begin
      case (r_state)
        IDLE: begin
          if (w_startRise) begin
            w_nextCounter = '0;
            w_nextSat     = 1'b0;
            w_nextState   = COUNT;
          end
        end
        COUNT: begin
          if (w_stopRise) begin
            w_nextFrequency = w_incCounter;
            w_nextOverflow  = w_incSat;
            w_nextValid     = 1'b1;
            if (w_startRise) begin
              w_nextCounter = '0;
              w_nextSat     = 1'b0;
            end else begin
              w_nextState   = IDLE;
            end
          end else if (w_startRise) begin
            w_nextCounter = '0;
            w_nextSat     = 1'b0;
          end else begin
            w_nextCounter = w_incCounter;
            w_nextSat     = w_incSat;
          end
        end
        default: begin
          w_nextState = IDLE;
        end
      endcase
    end
  end

  // State, count and published result registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_counter   <= '0;
      r_sat       <= 1'b0;
      r_frequency <= '0;
      r_overflow  <= 1'b0;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_counter   <= w_nextCounter;
      r_sat       <= w_nextSat;
      r_frequency <= w_nextFrequency;
      r_overflow  <= w_nextOverflow;
      r_valid     <= w_nextValid;
      r_busy      <= (w_nextState == COUNT);
    end
  end

  assign bus.frequency       = r_frequency;
  assign bus.frequency_valid = r_valid;
  assign bus.overflow        = r_overflow;
  assign bus.busy            = r_busy;

endmodule

// File: tb/tb_frequency_analyzer.sv
// Directed bench for the frequency analyzer: a 32-bit instance for the
// general behaviour and a 4-bit instance, fed identically, for saturation.
module tb_frequency_analyzer;

  logic clock = 1'b0;
  logic reset = 1'b1;

  int   vectorCount  = 0;
  int   missCount    = 0;
  int   samplePeriod = 100;
  int   samplePhase  = 0;
  logic sampleLevel  = 1'b0;
  int   validCount   = 0;
  logic prevValid    = 1'b0;
  logic doubleValid  = 1'b0;
  int   validBefore  = 0;

  frequency_analyzer_if #(.COUNTER_WIDTH(32)) busMain ();
  frequency_analyzer_if #(.COUNTER_WIDTH(4))  busSmall ();

  frequency_analyzer #(.COUNTER_WIDTH(32), .SYNC_STAGES(2)) dutMain (
    .clock (clock),
    .reset (reset),
    .bus   (busMain)
  );

  frequency_analyzer #(.COUNTER_WIDTH(4), .SYNC_STAGES(2)) dutSmall (
    .clock (clock),
    .reset (reset),
    .bus   (busSmall)
  );

  always #5 clock = ~clock;

  // Free-running square wave on sample_in, toggling every half period.
  initial begin
    busMain.sample_in  = 1'b0;
    busSmall.sample_in = 1'b0;
    forever begin
      @(negedge clock);
      samplePhase = samplePhase + 1;
      if (samplePhase >= samplePeriod / 2) begin
        samplePhase = 0;
        sampleLevel = ~sampleLevel;
      end
      busMain.sample_in  = sampleLevel;
      busSmall.sample_in = sampleLevel;
    end
  end

  // Counts valid pulses on the main instance and flags back-to-back pulses.
  initial begin
    forever begin
      @(negedge clock);
      if (busMain.frequency_valid === 1'b1) begin
        validCount = validCount + 1;
        if (prevValid) doubleValid = 1'b1;
      end
      prevValid = (busMain.frequency_valid === 1'b1);
    end
  end

  task automatic applyStimulus(input logic en, input logic st, input logic sp, input int cycles);
    busMain.enable          = en;
    busMain.start_analyzer  = st;
    busMain.stop_analyzer   = sp;
    busSmall.enable         = en;
    busSmall.start_analyzer = st;
    busSmall.stop_analyzer  = sp;
    repeat (cycles) @(negedge clock);
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectorCount = vectorCount + 1;
    assert (observed === expected)
      else begin
        missCount = missCount + 1;
        $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 4);
    checkOutput("reset.frequency", 64'(busMain.frequency), 64'd0);
    checkOutput("reset.valid", 64'(busMain.frequency_valid), 64'd0);
    checkOutput("reset.overflow", 64'(busMain.overflow), 64'd0);
    checkOutput("reset.busy", 64'(busMain.busy), 64'd0);
    checkOutput("reset.smallBusy", 64'(busSmall.busy), 64'd0);
    reset = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 60);

    // Basic 50000-cycle window, period 100 -> 500 edges
    validBefore = validCount;
    applyStimulus(1'b1, 1'b1, 1'b0, 20);
    checkOutput("basic.busyDuring", 64'(busMain.busy), 64'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 49980);
    applyStimulus(1'b1, 1'b0, 1'b1, 20);
    applyStimulus(1'b1, 1'b0, 1'b0, 10);
    checkOutput("basic.frequency", 64'(busMain.frequency), 64'd500);
    checkOutput("basic.overflow", 64'(busMain.overflow), 64'd0);
    checkOutput("basic.validPulses", 64'(validCount - validBefore), 64'd1);
    checkOutput("basic.busyAfter", 64'(busMain.busy), 64'd0);

    // Stop while idle: nothing published
    validBefore = validCount;
    applyStimulus(1'b1, 1'b0, 1'b1, 20);
    applyStimulus(1'b1, 1'b0, 1'b0, 10);
    checkOutput("idleStop.validPulses", 64'(validCount - validBefore), 64'd0);
    checkOutput("idleStop.frequency", 64'(busMain.frequency), 64'd500);
    checkOutput("idleStop.busy", 64'(busMain.busy), 64'd0);

    // Saturation: 200-cycle window, period 4 -> 50 edges
    samplePeriod = 4;
    applyStimulus(1'b1, 1'b0, 1'b0, 50);
    applyStimulus(1'b1, 1'b1, 1'b0, 20);
    applyStimulus(1'b1, 1'b0, 1'b0, 180);
    applyStimulus(1'b1, 1'b0, 1'b1, 20);
    applyStimulus(1'b1, 1'b0, 1'b0, 10);
    checkOutput("sat.smallFrequency", 64'(busSmall.frequency), 64'd15);
    checkOutput("sat.smallOverflow", 64'(busSmall.overflow), 64'd1);
    checkOutput("sat.mainFrequency", 64'(busMain.frequency), 64'd50);
    checkOutput("sat.mainOverflow", 64'(busMain.overflow), 64'd0);

    // Back-to-back windows of 1000 cycles, period 10
    samplePeriod = 10;
    applyStimulus(1'b1, 1'b0, 1'b0, 50);
    validBefore = validCount;
    applyStimulus(1'b1, 1'b1, 1'b0, 20);
    applyStimulus(1'b1, 1'b0, 1'b0, 980);
    applyStimulus(1'b1, 1'b1, 1'b1, 20);
    checkOutput("b2b.firstFrequency", 64'(busMain.frequency), 64'd100);
    checkOutput("b2b.firstValid", 64'(validCount - validBefore), 64'd1);
    checkOutput("b2b.busyHeld", 64'(busMain.busy), 64'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 980);
    applyStimulus(1'b1, 1'b0, 1'b1, 20);
    applyStimulus(1'b1, 1'b0, 1'b0, 10);
    checkOutput("b2b.secondFrequency", 64'(busMain.frequency), 64'd100);
    checkOutput("b2b.secondValid", 64'(validCount - validBefore), 64'd2);
    checkOutput("b2b.busyAfter", 64'(busMain.busy), 64'd0);

    // Enable gating: 300 disabled cycles inside a window of 1000 enabled cycles
    applyStimulus(1'b1, 1'b0, 1'b0, 50);
    validBefore = validCount;
    applyStimulus(1'b1, 1'b1, 1'b0, 20);
    applyStimulus(1'b1, 1'b0, 1'b0, 480);
    applyStimulus(1'b0, 1'b0, 1'b0, 300);
    checkOutput("gate.noValidWhileOff", 64'(validCount - validBefore), 64'd0);
    checkOutput("gate.busyHeld", 64'(busMain.busy), 64'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 500);
    applyStimulus(1'b1, 1'b0, 1'b1, 20);
    applyStimulus(1'b1, 1'b0, 1'b0, 10);
    checkOutput("gate.frequency", 64'(busMain.frequency), 64'd100);
    checkOutput("gate.validPulses", 64'(validCount - validBefore), 64'd1);

    // Reset 400 cycles into a window, then a fresh window
    applyStimulus(1'b1, 1'b0, 1'b0, 50);
    validBefore = validCount;
    applyStimulus(1'b1, 1'b1, 1'b0, 20);
    applyStimulus(1'b1, 1'b0, 1'b0, 380);
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 3);
    checkOutput("midReset.frequency", 64'(busMain.frequency), 64'd0);
    checkOutput("midReset.overflow", 64'(busMain.overflow), 64'd0);
    checkOutput("midReset.busy", 64'(busMain.busy), 64'd0);
    checkOutput("midReset.valid", 64'(busMain.frequency_valid), 64'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 2);
    reset = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 10);
    checkOutput("heldStart.busy", 64'(busMain.busy), 64'd0);
    checkOutput("midReset.noValid", 64'(validCount - validBefore), 64'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 50);
    applyStimulus(1'b1, 1'b1, 1'b0, 20);
    applyStimulus(1'b1, 1'b0, 1'b0, 980);
    applyStimulus(1'b1, 1'b0, 1'b1, 20);
    applyStimulus(1'b1, 1'b0, 1'b0, 10);
    checkOutput("freshWindow.frequency", 64'(busMain.frequency), 64'd100);
    checkOutput("freshWindow.validPulses", 64'(validCount - validBefore), 64'd1);

    // Valid never asserted two cycles in a row
    checkOutput("noDoubleValid", 64'(doubleValid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule

// File: doc/frequency_analyzer.md
FREQUENCY_ANALYZER -- requirements
Module: frequency_analyzer

Interface
REQ-001 Parameter COUNTER_WIDTH, default 32: width of the edge counter and the result.
REQ-002 Parameter SYNC_STAGES, default 2: number of synchronizer flops on sample_in; legal values 2..4.
REQ-003 clock  input  1  all logic on posedge clock.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 enable  input  1  global run qualifier.
REQ-006 start_analyzer  input  1  window-open level from the frequency synchronizer; synchronous to clock; may be held high for several cycles.
REQ-007 stop_analyzer  input  1  window-close level; same properties as start_analyzer.
REQ-008 sample_in  input  1  asynchronous signal under measurement.
REQ-009 frequency  output  COUNTER_WIDTH  rising-edge count of the last completed window; registered; holds until the next window completes.
REQ-010 frequency_valid  output  1  one-cycle pulse when frequency updates.
REQ-011 overflow  output  1  the last completed window saturated; updates with frequency.
REQ-012 busy  output  1  high while in COUNT.

Function
REQ-013 sample_in SHALL pass through SYNC_STAGES flops, then one edge register; sample_edge = sync & ~prev. sample_in rise to sample_edge assertion = SYNC_STAGES+1 cycles.
REQ-014 start_rise = start_analyzer & ~start_prev, and stop_rise likewise. start_prev and stop_prev SHALL update every cycle, including while enable=0.
REQ-015 FSM states: IDLE, COUNT. Reset state is IDLE.
REQ-016 IDLE: on start_rise -> counter <= 0, go to COUNT. stop_rise is ignored. sample_edge is not counted.
REQ-017 COUNT: each cycle with sample_edge, the counter SHALL increment by 1.
REQ-018 At counter = 2^COUNTER_WIDTH-1, the counter SHALL saturate and hold; an internal sat flag SHALL set and is cleared on window start.
REQ-019 COUNT with stop_rise:
  - frequency <= counter + sample_edge (saturating).
  - overflow <= sat, or the increment would saturate.
  - frequency_valid = 1 on the following cycle.
  - go to IDLE.
REQ-020 COUNT with start_rise and no stop_rise: the window SHALL restart (counter <= 0, sat <= 0). No result is produced.
REQ-021 COUNT with simultaneous start_rise and stop_rise:
  - result SHALL be latched and published per REQ-019.
  - counter <= 0 and state stays COUNT (back-to-back windows).
REQ-022 The cycle in which a window opens does not count a coincident sample_edge. The cycle carrying stop_rise does count one.
REQ-023 enable=0:
  - state, counter, sat, frequency and overflow hold.
  - start_rise and stop_rise are ignored.
  - sample_edge is not counted.
  - frequency_valid = 0.
  - The synchronizer and edge registers keep running.
REQ-024 frequency_valid SHALL never assert for two consecutive cycles.
REQ-025 busy = (state == COUNT), registered.

Reset
REQ-026 Reset SHALL clear the synchronizer chain, the edge registers, start_prev and stop_prev.
REQ-027 Reset SHALL clear the outputs: frequency = 0, frequency_valid = 0, overflow = 0, busy = 0, state = IDLE.
REQ-028 Reset mid-window SHALL discard the partial count. No frequency_valid is produced for that window.
REQ-029 An input held high across reset release SHALL NOT produce start_rise, stop_rise or sample_edge on the first cycle after release.

Verification
REQ-030 Basic window:
  - Stimulus: enable=1, start_analyzer high for 20 cycles, then 50000 cycles; sample_in square wave with period 100 cycles; stop_analyzer high for 20 cycles at cycle 50000.
  - Response: frequency = 500 ±1, one frequency_valid pulse, overflow = 0.
REQ-031 Saturation:
  - Stimulus: COUNTER_WIDTH=4, sample_in period 4 cycles, window 200 cycles.
  - Response: frequency = 15, overflow = 1.
REQ-032 Stop with no start:
  - Stimulus: stop_analyzer pulse while IDLE.
  - Response: no frequency_valid; frequency unchanged.
REQ-033 Back-to-back windows:
  - Stimulus: start_analyzer and stop_analyzer rise in the same cycle after a 1000-cycle window, sample_in period 10 cycles.
  - Response: frequency = 100; busy stays 1; the next window counts from 0.
REQ-034 Enable gating:
  - Stimulus: deassert enable for 300 cycles mid-window, sample_in period 10 cycles, 1000 enabled cycles in total.
  - Response: frequency = 100; no frequency_valid pulses while enable=0.
REQ-035 Reset mid-window:
  - Stimulus: assert reset at cycle 400 of a window, then a fresh 1000-cycle window.
  - Response: all outputs 0 after reset; the next result = 100 and comes from the new window only.
